store_buffer: RTL and testbench

- Sits directly upstream of the data memory, between the pipeline's memory stage and the single data-memory port.
- Accepts one load or store request per cycle and queues stores in a DEPTH-entry FIFO.
- Drains queued stores into memory in cycles when the port is free, and forwards the youngest matching buffered store data to loads.
- Load results are registered and returned one cycle after acceptance.

---
 rtl/store_buffer_pkg.sv | 17 +
 rtl/sb_fwd_match.sv | 38 +++
 rtl/store_buffer.sv | 151 +++++++++++++++
 tb/tb_store_buffer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// Shared CPU-side definitions for the store buffer: default widths,
// request-type encoding and the memory-port ownership type.
package store_buffer_pkg;

    localparam int CPU_AW = 16;
    localparam int CPU_DW = 16;

    localparam logic REQ_LOAD  = 1'b0;
    localparam logic REQ_STORE = 1'b1;

    typedef enum logic [1:0] {
        PORT_IDLE,
        PORT_LOAD,
        PORT_DRAIN
    } port_own_t;

endpackage

// File: rtl/sb_fwd_match.sv
// Youngest-match selector: scans entries from oldest (tail) to youngest
// (tail-1) so the last hit seen is the most recently written store.
module sb_fwd_match #(
    parameter int DEPTH = 4,
    parameter int AW    = 16,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0][AW-1:0] entry_addr,
    input  logic [DEPTH-1:0]         entry_valid,
    input  logic [PW-1:0]            tail,
    input  logic [AW-1:0]            addr,
    output logic                     hit,
    output logic [PW-1:0]            idx
);

    logic [DEPTH-1:0] match;
    logic [PW-1:0]    cand;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            assign match[gi] = entry_valid[gi] && (entry_addr[gi] == addr);
        end
    endgenerate

    always_comb begin
        hit  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            cand = tail - PW'(k);
            if (match[cand]) begin
                hit = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Store buffer in front of a single-port data memory: queues stores,
// drains them when no load owns the port, and forwards buffered data to loads.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = CPU_AW,
    parameter int DW    = CPU_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          req_ready,
    input  logic          flush,
    output logic          load_valid,
    output logic [DW-1:0] load_data,
    output logic          empty,
    output logic          full,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_data_in,
    output logic          mem_W,
    output logic          mem_R,
    input  logic [DW-1:0] mem_data_out
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0][AW-1:0] entry_addr_reg;
    logic [DEPTH-1:0][DW-1:0] entry_data_reg;
    logic [DEPTH-1:0]         entry_valid_reg;
    logic [PW-1:0]            head_reg, head_next;
    logic [PW-1:0]            tail_reg, tail_next;
    logic [CW-1:0]            count_reg, count_next;
    logic                     load_valid_reg;
    logic [DW-1:0]            load_data_reg;

    logic      load_acc;
    logic      store_acc;
    logic      drain;
    port_own_t port_own;
    logic      fwd_hit;
    logic [PW-1:0] fwd_idx;
    logic [DW-1:0] load_sel;

    assign empty     = (count_reg == '0);
    assign full      = (count_reg == CW'(DEPTH));
    assign req_ready = !flush && !(req_we && full);
    assign load_acc  = req_valid && req_ready && (req_we == REQ_LOAD);
    assign store_acc = req_valid && req_ready && (req_we == REQ_STORE);
    // The load owns the port for its cycle, so a drain only happens otherwise.
    assign drain     = !load_acc && !empty;

    sb_fwd_match #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .PW    (PW)
    ) u_fwd (
        .entry_addr  (entry_addr_reg),
        .entry_valid (entry_valid_reg),
        .tail        (tail_reg),
        .addr        (req_addr),
        .hit         (fwd_hit),
        .idx         (fwd_idx)
    );

    assign load_sel = fwd_hit ? entry_data_reg[fwd_idx] : mem_data_out;

    always_comb begin
        port_own = PORT_IDLE;
        if (load_acc) begin
            port_own = PORT_LOAD;
        end else if (drain) begin
            port_own = PORT_DRAIN;
        end
    end

    always_comb begin
        mem_W       = 1'b0;
        mem_R       = 1'b0;
        mem_address = '0;
        mem_data_in = '0;
        case (port_own)
            PORT_LOAD: begin
                mem_R       = 1'b1;
                mem_address = req_addr;
            end
            PORT_DRAIN: begin
                mem_W       = 1'b1;
                mem_address = entry_addr_reg[head_reg];
                mem_data_in = entry_data_reg[head_reg];
            end
            default: ;
        endcase
    end

    always_comb begin
        head_next  = drain ? head_reg + PW'(1) : head_reg;
        tail_next  = store_acc ? tail_reg + PW'(1) : tail_reg;
        count_next = count_reg;
        case ({store_acc, drain})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_reg       <= '0;
            tail_reg       <= '0;
            count_reg      <= '0;
            load_valid_reg <= 1'b0;
            load_data_reg  <= '0;
        end else begin
            head_reg       <= head_next;
            tail_reg       <= tail_next;
            count_reg      <= count_next;
            load_valid_reg <= load_acc;
            if (load_acc) begin
                load_data_reg <= load_sel;
            end
        end
    end

    // Store and drain never target the same slot: both imply 0 < count < DEPTH.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    entry_addr_reg[gi]  <= '0;
                    entry_data_reg[gi]  <= '0;
                    entry_valid_reg[gi] <= 1'b0;
                end else if (store_acc && (tail_reg == PW'(gi))) begin
                    entry_addr_reg[gi]  <= req_addr;
                    entry_data_reg[gi]  <= req_wdata;
                    entry_valid_reg[gi] <= 1'b1;
                end else if (drain && (head_reg == PW'(gi))) begin
                    entry_valid_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    assign load_valid = load_valid_reg;
    assign load_data  = load_data_reg;

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus random traffic
// against a queue-based model of the buffer and a shadow copy of memory.
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_we;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        req_ready;
    logic        flush;
    logic        load_valid;
    logic [15:0] load_data;
    logic        empty;
    logic        full;
    logic [15:0] mem_address;
    logic [15:0] mem_data_in;
    logic        mem_W;
    logic        mem_R;
    logic [15:0] mem_data_out;

    store_buffer #(.DEPTH(DEPTH), .AW(16), .DW(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_ready    (req_ready),
        .flush        (flush),
        .load_valid   (load_valid),
        .load_data    (load_data),
        .empty        (empty),
        .full         (full),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_W        (mem_W),
        .mem_R        (mem_R),
        .mem_data_out (mem_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: unwritten words read back a fixed per-address pattern.
    bit [15:0] mem     [0:255];
    bit        written [0:255];

    function automatic logic [15:0] init_val(input logic [15:0] a);
        return (a == 16'd6) ? 16'h000A : {8'hA5, a[7:0]};
    endfunction

    function automatic logic [15:0] mem_rd(input int a);
        return written[a] ? mem[a] : init_val(16'(a));
    endfunction

    assign mem_data_out = mem_rd(int'(mem_address[7:0]));

    always @(posedge clk) begin
        if (mem_W) begin
            mem[mem_address[7:0]]     <= mem_data_in;
            written[mem_address[7:0]] <= 1'b1;
        end
    end

    typedef struct {
        logic [15:0] a;
        logic [15:0] d;
    } ent_t;

    ent_t        q[$];
    logic [15:0] ref_mem [0:255];
    logic [15:0] ld_hold;
    logic [15:0] last_ld;
    logic        last_ready_dut;
    bit          last_acc;
    int          total;
    int          bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at posedge+1, check combinational outputs at
    // posedge+4, then advance the model and check registered outputs.
    task automatic step(input bit v, input bit we, input logic [15:0] a,
                        input logic [15:0] d, input bit fl);
        bit          rdy, ld, dr;
        logic [15:0] fw, ea, ed;
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        flush     = fl;
        #3;
        rdy = !fl && !(we && q.size() == DEPTH);
        ld  = v && rdy && !we;
        dr  = !ld && (q.size() > 0);
        fw  = ref_mem[a[7:0]];
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].a == a) fw = q[i].d;
        end
        ea = 16'h0;
        ed = 16'h0;
        if (ld) begin
            ea = a;
        end else if (dr) begin
            ea = q[0].a;
            ed = q[0].d;
        end
        chk("req_ready",   32'(req_ready),   32'(rdy));
        chk("mem_R",       32'(mem_R),       32'(ld));
        chk("mem_W",       32'(mem_W),       32'(dr));
        chk("mem_address", 32'(mem_address), 32'(ea));
        chk("mem_data_in", 32'(mem_data_in), 32'(ed));
        chk("empty",       32'(empty),       32'(q.size() == 0));
        chk("full",        32'(full),        32'(q.size() == DEPTH));
        last_ready_dut = req_ready;
        @(posedge clk);
        #1;
        if (dr) begin
            ref_mem[q[0].a[7:0]] = q[0].d;
            void'(q.pop_front());
        end
        if (v && rdy && we) q.push_back('{a: a, d: d});
        if (ld) ld_hold = fw;
        chk("load_valid", 32'(load_valid), 32'(ld));
        chk("load_data",  32'(load_data),  32'(ld_hold));
        last_acc = v && rdy;
        last_ld  = load_data;
    endtask

    task automatic idle_until_empty();
        for (int n = 0; n < 8 && q.size() > 0; n++) step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        chk("drain_bound", 32'(q.size()), 32'd0);
    endtask

    task automatic store_retry(input logic [15:0] a, input logic [15:0] d, output int stalls);
        stalls = 0;
        last_acc = 1'b0;
        for (int n = 0; n < 4 && !last_acc; n++) begin
            step(1'b1, 1'b1, a, d, 1'b0);
            if (!last_ready_dut) stalls++;
        end
        chk("store_accept_bound", 32'(last_acc), 32'd1);
    endtask

    initial begin
        int stalls;
        total = 0;
        bad   = 0;
        ld_hold = 16'h0;
        last_ld = 16'h0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(16'(i));
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 16'h0;
        req_wdata = 16'h0;
        flush     = 1'b0;
        #1;
        chk("rst_load_valid", 32'(load_valid), 32'd0);
        chk("rst_load_data",  32'(load_data),  32'd0);
        chk("rst_empty",      32'(empty),      32'd1);
        chk("rst_full",       32'(full),       32'd0);
        chk("rst_mem_W",      32'(mem_W),      32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Load from memory with no buffered stores.
        step(1'b1, 1'b0, 16'd6, 16'h0, 1'b0);
        chk("load6", 32'(last_ld), 32'h000A);

        // Store then immediate load of the same address.
        step(1'b1, 1'b1, 16'd3, 16'h1234, 1'b0);
        step(1'b1, 1'b0, 16'd3, 16'h0, 1'b0);
        chk("fwd3", 32'(last_ld), 32'h1234);
        step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        chk("mem3", 32'(mem_rd(3)), 32'h1234);
        chk("empty_after3", 32'(empty), 32'd1);

        // Repeated stores to one address, then a load.
        step(1'b1, 1'b1, 16'd5, 16'h1111, 1'b0);
        step(1'b1, 1'b1, 16'd5, 16'h2222, 1'b0);
        step(1'b1, 1'b1, 16'd5, 16'h3333, 1'b0);
        step(1'b1, 1'b0, 16'd5, 16'h0, 1'b0);
        chk("fwd5_youngest", 32'(last_ld), 32'h3333);
        idle_until_empty();
        chk("mem5", 32'(mem_rd(5)), 32'h3333);

        // Five back-to-back stores to distinct addresses.
        for (int i = 0; i < 5; i++) store_retry(16'(8 + i), 16'(16'hC000 + i), stalls);
        idle_until_empty();
        for (int i = 0; i < 5; i++) chk("b2b_mem", 32'(mem_rd(8 + i)), 32'(16'hC000 + i));

        // Flush with a pending store and a request held high.
        step(1'b1, 1'b1, 16'd14, 16'h5A5A, 1'b0);
        step(1'b1, 1'b1, 16'd15, 16'h7777, 1'b1);
        chk("flush_blocks", 32'(last_ready_dut), 32'd0);
        step(1'b1, 1'b1, 16'd15, 16'h7777, 1'b1);
        chk("flush_empty", 32'(empty), 32'd1);
        step(1'b1, 1'b1, 16'd15, 16'h7777, 1'b0);
        chk("flush_release", 32'(last_ready_dut), 32'd1);
        idle_until_empty();
        chk("mem14", 32'(mem_rd(14)), 32'h5A5A);

        // Reset in the middle of a pending drain discards the store.
        step(1'b1, 1'b0, 16'd6, 16'h0, 1'b0);
        step(1'b1, 1'b1, 16'd20, 16'hBEEF, 1'b0);
        req_valid = 1'b0;
        #2;
        chk("pre_rst_drain", 32'(mem_W), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_empty",      32'(empty),      32'd1);
        chk("midrst_load_valid", 32'(load_valid), 32'd0);
        chk("midrst_load_data",  32'(load_data),  32'd0);
        chk("midrst_mem_W",      32'(mem_W),      32'd0);
        q.delete();
        ld_hold = 16'h0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b1, 1'b0, 16'd20, 16'h0, 1'b0);
        chk("load20_orig", 32'(last_ld), 32'hA514);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 16'($urandom_range(0, 15)), 16'($urandom),
                 ($urandom_range(0, 15) == 0));
        end
        idle_until_empty();
        for (int i = 0; i < 32; i++) chk("final_mem", 32'(mem_rd(i)), 32'(ref_mem[i]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
